mio_arbiter: RTL and testbench
==============================

Name: mio_arbiter

Overview:
- Two-master arbiter that shares the single memory/IO bus between master 0 (the CPU's MIO request port) and master 1 (an auxiliary DMA/peripheral master).
- Serialises one transaction at a time to the slave, returns read data and a one-cycle ready pulse to the winner, and aborts hung accesses with a timeout.
- Sits between the CPU top and the memory/IO decoder. Master 0 ready feeds the CPU's MIO_ready input.

Parameters:
- TIMEOUT, 16, maximum cycles in BUSY without s_ack before the transaction is aborted (≥2).
- CW, 5, width of the timeout counter (2^CW > TIMEOUT).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. Asserted when 0.
- m0_req  in  1  master 0 request (CPU_MIO); held until m0_ready.
- m0_we  in  1  master 0 write enable (mem_w).
- m0_addr  in  32  master 0 address.
- m0_wdata  in  32  master 0 write data.
- m0_ready  out  1  one-cycle completion pulse to master 0.
- m1_req, m1_we, m1_addr, m1_wdata  in  1/1/32/32  master 1 request group, same rules as master 0.
- m1_ready  out  1  one-cycle completion pulse to master 1.
- rdata  out  32  read data for the completed transaction; valid while a ready is high.
- err  out  1  high together with a ready pulse when that transaction timed out.
- s_en  out  1  slave access strobe.
- s_we  out  1  slave write enable.
- s_addr  out  32  slave address.
- s_wdata  out  32  slave write data.
- s_rdata  in  32  slave read data, sampled when s_ack=1.
- s_ack  in  1  slave completion.
- grant  out  2  one-hot current owner (01=m0, 10=m1, 00=none).
- state  out  2  FSM state for test: IDLE=0, BUSY=1, DONE=2.

Behaviour:
- Reset (reset=0, async) drives the following values:
  - state=IDLE, grant=00.
  - s_en=0, s_we=0, s_addr=0, s_wdata=0.
  - rdata=0, err=0, m0_ready=0, m1_ready=0.
  - Timeout counter = 0.
  - last_owner = m1, so the first tie goes to m0.
- All outputs are registered.
- IDLE:
  - Any req sampled high selects an owner and moves to BUSY on the next edge.
  - On that edge, latch grant and load s_addr/s_wdata/s_we from the owner; s_en becomes 1.
  - Only one req high: that master wins.
  - Both high: the master that is not last_owner wins (round-robin).
  - No req: stay in IDLE with s_en=0.
- BUSY:
  - s_en stays 1; address, data and we stay stable. Later changes on master inputs are ignored.
  - The counter increments each cycle.
  - s_ack=1 → next edge: rdata←s_rdata (writes: rdata←s_rdata as returned), owner ready=1, err=0, s_en=0, s_we=0, state=DONE, last_owner←owner.
  - No ack and counter = TIMEOUT-1 → next edge: rdata←0, owner ready=1, err=1, s_en=0, state=DONE, last_owner←owner.
  - If s_ack arrives in the same cycle the counter hits TIMEOUT-1, the ack wins (err=0).
- DONE (one cycle):
  - Ready/err are high for exactly this cycle.
  - The master must drop req on the edge that ends DONE.
  - Next edge: ready=0, err=0, grant=00, counter=0, state=IDLE.
  - A request already pending from the other master is arbitrated in that IDLE cycle.
- Latency:
  - req high at edge k → s_en high after edge k+1.
  - s_ack at cycle j → ready high for the cycle after edge j+1.
  - Minimum request-to-ready time is 3 cycles; back-to-back throughput is one transaction per 3 cycles + slave wait.
- Inputs s_ack/s_rdata are ignored outside BUSY.
- Reset mid-transaction aborts immediately: no ready pulse, s_en drops asynchronously.

Test Plan:
1. Single read: m0_req=1, m0_addr=0x0000_0010, m0_we=0; slave acks 2 cycles after s_en with s_rdata=0x1234_5678 → s_addr=0x10, s_we=0, then m0_ready pulse one cycle with rdata=0x1234_5678, err=0, grant returns to 00.
2. Write: m1_req=1, m1_we=1, m1_addr=0xE000_0000, m1_wdata=0xA5A5_A5A5, slave acks immediately → s_we=1, s_wdata=0xA5A5_A5A5 during BUSY; m1_ready pulse; m0_ready stays 0.
3. Contention after reset: both req high in the same cycle → m0 granted first (grant=01). After its ready, m1 is granted (10) without m0 dropping priority for new requests. With both continuously requesting, grants alternate 01,10,01,10.
4. Timeout with TIMEOUT=16: slave never acks → exactly 16 BUSY cycles, then ready pulse with err=1, rdata=0. Ack on the 16th BUSY cycle → err=0, rdata from slave.
5. Reset mid-BUSY: reset=0 while s_en=1 → s_en=0, grant=00, state=0 without a clock edge; no ready pulse. After release, a fresh m0 request completes normally.
6. Input stability: change m0_addr during BUSY → s_addr holds the value latched at grant.

Source files
------------

// File: rtl/mio_arbiter.sv
// mio_arbiter: two-master round-robin arbiter for the shared memory/IO bus.
// One transaction is in flight at a time. Every output is registered. A slave
// that never acknowledges is cut off after TIMEOUT busy cycles, and the owner
// then gets an error completion.
module mio_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic        s_en,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_ack,
    output logic [1:0]  grant,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Value of the busy counter on the last busy cycle before the abort.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          s_en_q, s_en_d;
    logic          s_we_q, s_we_d;
    logic [31:0]   s_addr_q, s_addr_d;
    logic [31:0]   s_wdata_q, s_wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          m0_ready_q, m0_ready_d;
    logic          m1_ready_q, m1_ready_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // 1 when master 1 owned the previous transaction, 0 when master 0 did.
    logic          last_m1_q, last_m1_d;

    logic          pick_m1;
    logic          owner_m1;

    // Round-robin pick. A lone requester always wins. On a tie, the master
    // that did not own the previous transaction wins.
    always_comb begin
        pick_m1 = 1'b0;
        if (m0_req && m1_req) begin
            pick_m1 = !last_m1_q;
        end else begin
            pick_m1 = m1_req;
        end
    end

    // The one-hot grant register records the current owner.
    assign owner_m1 = grant_q[1];

    // Next-state and output logic for the IDLE -> BUSY -> DONE handshake.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        s_en_d     = s_en_q;
        s_we_d     = s_we_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
        m0_ready_d = 1'b0;
        m1_ready_d = 1'b0;
        cnt_d      = cnt_q;
        last_m1_d  = last_m1_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m0_req || m1_req) begin
                    state_d = BUSY;
                    s_en_d  = 1'b1;
                    if (pick_m1) begin
                        grant_d   = 2'b10;
                        s_we_d    = m1_we;
                        s_addr_d  = m1_addr;
                        s_wdata_d = m1_wdata;
                    end else begin
                        grant_d   = 2'b01;
                        s_we_d    = m0_we;
                        s_addr_d  = m0_addr;
                        s_wdata_d = m0_wdata;
                    end
                end else begin
                    s_en_d = 1'b0;
                end
            end

            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (s_ack) begin
                    state_d    = DONE;
                    rdata_d    = s_rdata;
                    err_d      = 1'b0;
                    s_en_d     = 1'b0;
                    s_we_d     = 1'b0;
                    m0_ready_d = !owner_m1;
                    m1_ready_d = owner_m1;
                    last_m1_d  = owner_m1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = DONE;
                    rdata_d    = '0;
                    err_d      = 1'b1;
                    s_en_d     = 1'b0;
                    s_we_d     = 1'b0;
                    m0_ready_d = !owner_m1;
                    m1_ready_d = owner_m1;
                    last_m1_d  = owner_m1;
                end
            end

            DONE: begin
                state_d = IDLE;
                grant_d = 2'b00;
                cnt_d   = '0;
            end

            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
                s_en_d  = 1'b0;
                s_we_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers. Reset is asynchronous, so a transaction in
    // flight is dropped at once and its owner gets no ready pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            s_en_q     <= 1'b0;
            s_we_q     <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            cnt_q      <= '0;
            last_m1_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            s_en_q     <= s_en_d;
            s_we_q     <= s_we_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            m0_ready_q <= m0_ready_d;
            m1_ready_q <= m1_ready_d;
            cnt_q      <= cnt_d;
            last_m1_q  <= last_m1_d;
        end
    end

    assign state    = state_q;
    assign grant    = grant_q;
    assign s_en     = s_en_q;
    assign s_we     = s_we_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign rdata    = rdata_q;
    assign err      = err_q;
    assign m0_ready = m0_ready_q;
    assign m1_ready = m1_ready_q;

endmodule

// File: tb/tb_mio_arbiter.sv
// tb_mio_arbiter: directed and randomized transactions for mio_arbiter.
// The reference model works one transaction at a time. It takes the winner
// from the round-robin rule, the busy length from the ack delay and TIMEOUT,
// and the completion data from what the slave returned.
module tb_mio_arbiter;

    localparam int TIMEOUT = 16;
    localparam int CW      = 5;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ready, m1_ready;
    logic [31:0] rdata;
    logic        err;
    logic        s_en, s_we;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_ack;
    logic [1:0]  grant;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    // Model: 1 when master 1 owned the last completed transaction.
    bit model_last_m1 = 1'b1;

    mio_arbiter #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready),
        .rdata(rdata), .err(err),
        .s_en(s_en), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack),
        .grant(grant), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction: present the requests in IDLE, play the slave
    // with the given ack delay (counted in busy cycles, 0 = first busy cycle),
    // then check the completion and the return to IDLE.
    task automatic applyStimulus(input bit r0, input bit r1, input bit we0, input bit we1,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input int ack_delay, input logic [31:0] slave_data);
        bit          win_m1;
        bit          exp_err;
        int          exp_busy;
        int          n;
        logic [31:0] exp_addr, exp_wdata, exp_rdata;
        bit          exp_we;

        win_m1    = (r0 && r1) ? !model_last_m1 : r1;
        exp_addr  = win_m1 ? a1 : a0;
        exp_wdata = win_m1 ? d1 : d0;
        exp_we    = win_m1 ? we1 : we0;
        exp_err   = (ack_delay >= TIMEOUT);
        exp_busy  = exp_err ? TIMEOUT : ack_delay + 1;
        exp_rdata = exp_err ? 32'h0 : slave_data;

        m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
        s_ack  = 1'b0;
        @(posedge clk); #1;

        checkOutput("busy_state", 32'(state), 32'd1);
        checkOutput("grant", 32'(grant), win_m1 ? 32'd2 : 32'd1);
        checkOutput("s_we", 32'(s_we), 32'(exp_we));
        checkOutput("s_wdata", s_wdata, exp_wdata);

        // The owner now scrambles its address; the latched one must hold.
        if (win_m1) m1_addr = $urandom; else m0_addr = $urandom;

        n = 0;
        while (n < 40 && state == 2'd1) begin
            checkOutput("s_en_busy", 32'(s_en), 32'd1);
            checkOutput("s_addr_hold", s_addr, exp_addr);
            s_ack   = (n == ack_delay);
            s_rdata = (n == ack_delay) ? slave_data : $urandom;
            n++;
            @(posedge clk); #1;
        end
        checkOutput("busy_cycles", 32'(n), 32'(exp_busy));

        checkOutput("done_state", 32'(state), 32'd2);
        checkOutput("m0_ready", 32'(m0_ready), win_m1 ? 32'd0 : 32'd1);
        checkOutput("m1_ready", 32'(m1_ready), win_m1 ? 32'd1 : 32'd0);
        checkOutput("err", 32'(err), 32'(exp_err));
        checkOutput("rdata", rdata, exp_rdata);
        checkOutput("s_en_done", 32'(s_en), 32'd0);

        // Winner drops its request; the slave lines are noise outside BUSY.
        if (win_m1) m1_req = 1'b0; else m0_req = 1'b0;
        s_ack   = 1'b1;
        s_rdata = $urandom;
        @(posedge clk); #1;
        s_ack = 1'b0;

        checkOutput("idle_state", 32'(state), 32'd0);
        checkOutput("idle_grant", 32'(grant), 32'd0);
        checkOutput("idle_m0_ready", 32'(m0_ready), 32'd0);
        checkOutput("idle_m1_ready", 32'(m1_ready), 32'd0);
        checkOutput("idle_err", 32'(err), 32'd0);
        model_last_m1 = win_m1;
    endtask

    initial begin
        bit          p0, p1, r0, r1;
        int          dly;
        logic [31:0] ra0, ra1;

        reset = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        s_ack = 0; s_rdata = 0;
        #3;
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_s_en", 32'(s_en), 32'd0);
        checkOutput("rst_s_addr", s_addr, 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_ready", 32'({m0_ready, m1_ready, err}), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_no_req", 32'(s_en), 32'd0);

        $display("[TB] single read");
        applyStimulus(1, 0, 0, 0, 32'h0000_0010, 32'h0, 32'h0, 32'h0, 2, 32'h1234_5678);

        $display("[TB] write from master 1");
        applyStimulus(0, 1, 0, 1, 32'h0, 32'hE000_0000, 32'h0, 32'hA5A5_A5A5, 0, 32'hDEAD_0001);

        // Reset to restore the tie preference, then both masters contend.
        reset = 1'b0; #2; reset = 1'b1;
        model_last_m1 = 1'b1;
        @(posedge clk); #1;
        $display("[TB] contention alternation");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 0, 0, 32'h100 + 32'(i), 32'h200 + 32'(i), 32'h0, 32'h0,
                          1, 32'hC0DE_0000 + 32'(i));
        end

        $display("[TB] timeout boundary");
        applyStimulus(1, 0, 0, 0, 32'h40, 32'h0, 32'h0, 32'h0, 99, 32'hBAD0_BAD0);
        applyStimulus(0, 1, 0, 0, 32'h0, 32'h44, 32'h0, 32'h0, TIMEOUT - 1, 32'h600D_600D);
        applyStimulus(1, 0, 1, 0, 32'h48, 32'h0, 32'h77, 32'h0, TIMEOUT, 32'h1111_2222);

        $display("[TB] reset during busy");
        m0_req = 1; m0_we = 0; m0_addr = 32'h80; m1_req = 0;
        @(posedge clk); #1;
        checkOutput("pre_rst_s_en", 32'(s_en), 32'd1);
        #2; reset = 1'b0; #1;
        checkOutput("async_s_en", 32'(s_en), 32'd0);
        checkOutput("async_grant", 32'(grant), 32'd0);
        checkOutput("async_state", 32'(state), 32'd0);
        s_ack = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_no_ready", 32'({m0_ready, m1_ready}), 32'd0);
        s_ack = 1'b0; m0_req = 1'b0;
        @(negedge clk); reset = 1'b1;
        model_last_m1 = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1, 0, 0, 0, 32'h84, 32'h0, 32'h0, 32'h0, 3, 32'h0BAD_F00D);

        $display("[TB] randomized traffic");
        p0 = 0; p1 = 0;
        for (int i = 0; i < 30; i++) begin
            r0 = p0 | ($urandom_range(0, 1) == 1);
            r1 = p1 | ($urandom_range(0, 1) == 1);
            if (!r0 && !r1) r0 = 1;
            dly = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 4);
            ra0 = $urandom; ra1 = $urandom;
            applyStimulus(r0, r1, 1'($urandom), 1'($urandom), ra0, ra1,
                          $urandom, $urandom, dly, $urandom);
            p0 = r0 && model_last_m1;
            p1 = r1 && !model_last_m1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
